// File: rtl/systolic_mm_nxn.sv
// rtl/systolic_mm_nxn.sv - output-stationary NxN systolic matrix multiplier
module systolic_mm_nxn #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 2*DW + $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              signed_mode,
    input  logic [N*N*DW-1:0] a_mat,
    input  logic [N*N*DW-1:0] b_mat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*AW-1:0] c_mat,
    output logic              busy
);

    localparam int L  = 2*N - 1;
    localparam int TW = $clog2(3*N);
    localparam logic [TW-1:0] T_LAST = TW'(3*N - 3);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

    state_t        state, state_next;
    logic          accept;
    logic          signed_q;
    logic [TW-1:0] t;

    // Feeder shift registers: row i of A (column j of B) is pre-skewed by i (j) zero slots.
    logic [DW-1:0] a_sr [N][L];
    logic [DW-1:0] b_sr [N][L];
    logic [DW-1:0] a_q  [N][N-1];
    logic [DW-1:0] b_q  [N-1][N];
    logic [DW-1:0] a_in [N][N];
    logic [DW-1:0] b_in [N][N];
    logic [AW-1:0] prod [N][N];
    logic [AW-1:0] acc  [N][N];

    // Out-of-range coordinates yield zero; indices are clamped so the select stays legal.
    function automatic logic [DW-1:0] elem(input logic [N*N*DW-1:0] m, input int r, input int c);
        int  rr;
        int  cc;
        logic ok;
        ok = (r >= 0) && (r < N) && (c >= 0) && (c < N);
        rr = ok ? r : 0;
        cc = ok ? c : 0;
        return ok ? m[(N*N-1-(rr*N+cc))*DW +: DW] : '0;
    endfunction

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (t == T_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            signed_q <= 1'b0;
            t        <= '0;
            for (int i = 0; i < N; i++) begin
                for (int p = 0; p < L; p++) begin
                    a_sr[i][p] <= '0;
                    b_sr[i][p] <= '0;
                end
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0;
                end
                for (int j = 0; j < N-1; j++) begin
                    a_q[i][j] <= '0;
                    b_q[j][i] <= '0;
                end
            end
        end else if (accept) begin
            signed_q <= signed_mode;
            t        <= '0;
            for (int i = 0; i < N; i++) begin
                for (int p = 0; p < L; p++) begin
                    a_sr[i][p] <= elem(a_mat, i, p - i);
                    b_sr[i][p] <= elem(b_mat, p - i, i);
                end
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0;
                end
                for (int j = 0; j < N-1; j++) begin
                    a_q[i][j] <= '0;
                    b_q[j][i] <= '0;
                end
            end
        end else if (state == S_COMPUTE) begin
            t <= t + 1'b1;
            for (int i = 0; i < N; i++) begin
                for (int p = 0; p < L-1; p++) begin
                    a_sr[i][p] <= a_sr[i][p+1];
                    b_sr[i][p] <= b_sr[i][p+1];
                end
                a_sr[i][L-1] <= '0;
                b_sr[i][L-1] <= '0;
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= acc[i][j] + prod[i][j];
                end
                for (int j = 0; j < N-1; j++) begin
                    a_q[i][j] <= a_in[i][j];
                    b_q[j][i] <= b_in[j][i];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [2*DW+1:0] a_ext;
            logic signed [2*DW+1:0] b_ext;
            logic signed [2*DW+1:0] p;

            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = a_sr[i][0];
            end else begin : g_a_inner
                assign a_in[i][j] = a_q[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in[i][j] = b_sr[j][0];
            end else begin : g_b_inner
                assign b_in[i][j] = b_q[i-1][j];
            end

            // Extending to 2DW+2 bits covers both the signed and the unsigned product range.
            assign a_ext = $signed({{(DW+2){signed_q & a_in[i][j][DW-1]}}, a_in[i][j]});
            assign b_ext = $signed({{(DW+2){signed_q & b_in[i][j][DW-1]}}, b_in[i][j]});
            assign p     = a_ext * b_ext;
            assign prod[i][j] = AW'(p);

            assign c_mat[(N*N-1-(i*N+j))*AW +: AW] = acc[i][j];
        end
    end

endmodule

// File: tb/tb_systolic_mm_nxn.sv
// tb/tb_systolic_mm_nxn.sv - directed bench for systolic_mm_nxn (N=4, N=2/DW=4, N=8)
module tb_systolic_mm_nxn;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic         in_valid4, in_ready4, signed4, out_valid4, out_ready4, busy4;
    logic [127:0] a4, b4;
    logic [287:0] c4;

    logic         in_valid2, in_ready2, signed2, out_valid2, out_ready2, busy2;
    logic [15:0]  a2, b2;
    logic [35:0]  c2;

    logic          in_valid8, in_ready8, signed8, out_valid8, out_ready8, busy8;
    logic [511:0]  a8, b8;
    logic [1215:0] c8;

    int total = 0;
    int bad   = 0;

    systolic_mm_nxn #(.N(4), .DW(8)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .signed_mode(signed4), .a_mat(a4), .b_mat(b4), .out_valid(out_valid4),
        .out_ready(out_ready4), .c_mat(c4), .busy(busy4)
    );

    systolic_mm_nxn #(.N(2), .DW(4)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .signed_mode(signed2), .a_mat(a2), .b_mat(b2), .out_valid(out_valid2),
        .out_ready(out_ready2), .c_mat(c2), .busy(busy2)
    );

    systolic_mm_nxn #(.N(8), .DW(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .signed_mode(signed8), .a_mat(a8), .b_mat(b8), .out_valid(out_valid8),
        .out_ready(out_ready8), .c_mat(c8), .busy(busy8)
    );

    function automatic logic [17:0] c4_at(input int r, input int c);
        return c4[(15-(r*4+c))*18 +: 18];
    endfunction

    function automatic logic [127:0] ident4();
        logic [127:0] v;
        v = '0;
        for (int r = 0; r < 4; r++) v[(15-(r*4+r))*8 +: 8] = 8'd1;
        return v;
    endfunction

    function automatic logic [127:0] seq4();
        logic [127:0] v;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[(15-(r*4+c))*8 +: 8] = 8'(4*r + c + 1);
        return v;
    endfunction

    task automatic start4(input logic sm);
        @(negedge clk);
        signed4   = sm;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
    endtask

    task automatic wait_out4(output int lat);
        lat = 0;
        while (!out_valid4 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready4); end
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid4); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy4); end
        total++; if (c4 !== '0) begin bad++; $display("FAIL reset_c_mat got=%h want=0", c4); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_identity();
        int lat;
        out_ready4 = 1'b1;
        a4 = ident4();
        b4 = seq4();
        start4(1'b0);
        a4 = '1;
        total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL id_in_ready_low got=%b want=0", in_ready4); end
        total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL id_busy got=%b want=1", busy4); end
        wait_out4(lat);
        total++; if (lat !== 10) begin bad++; $display("FAIL id_latency got=%0d want=10", lat); end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                total++;
                if (c4_at(r, c) !== 18'(4*r + c + 1)) begin
                    bad++; $display("FAIL id_c[%0d][%0d] got=%0d want=%0d", r, c, c4_at(r, c), 4*r + c + 1);
                end
            end
        @(posedge clk);
        #1;
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL id_out_valid_pulse got=%b want=0", out_valid4); end
        total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL id_in_ready_back got=%b want=1", in_ready4); end
    endtask

    task automatic test_unsigned_max();
        int lat;
        a4 = '1;
        b4 = '1;
        start4(1'b0);
        wait_out4(lat);
        total++; if (lat !== 10) begin bad++; $display("FAIL umax_latency got=%0d want=10", lat); end
        total++; if (c4 !== {16{18'd260100}}) begin bad++; $display("FAIL umax_c got=%h want all 260100", c4); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_signed();
        int lat;
        a4 = {16{8'hFF}};
        b4 = {16{8'h02}};
        start4(1'b1);
        wait_out4(lat);
        total++; if (c4 !== {16{18'h3FFF8}}) begin bad++; $display("FAIL signed_c got=%h want all 3fff8", c4); end
        @(posedge clk);
        #1;
        start4(1'b0);
        wait_out4(lat);
        total++; if (c4 !== {16{18'd2040}}) begin bad++; $display("FAIL unsigned_ff_c got=%h want all 2040", c4); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [287:0] exp_c;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_c[(15-(r*4+c))*18 +: 18] = 18'(4*r + c + 1);
        out_ready4 = 1'b0;
        a4 = ident4();
        b4 = seq4();
        start4(1'b0);
        wait_out4(lat);
        total++; if (lat !== 10) begin bad++; $display("FAIL bp_latency got=%0d want=10", lat); end
        @(negedge clk);
        in_valid4 = 1'b1;
        a4 = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                a4[(15-(r*4+c))*8 +: 8] = 8'd1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || c4 !== exp_c) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d out_valid=%b in_ready=%b c=%h want valid=1 ready=0 c=%h",
                         k, out_valid4, in_ready4, c4, exp_c);
            end
        end
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        total++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
            bad++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready4, out_valid4);
        end
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL b2b_accept in_ready=%b want=0", in_ready4); end
        wait_out4(lat);
        total++; if (lat !== 10) begin bad++; $display("FAIL b2b_latency got=%0d want=10", lat); end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                total++;
                if (c4_at(r, c) !== 18'(28 + 4*c)) begin
                    bad++; $display("FAIL b2b_c[%0d][%0d] got=%0d want=%0d", r, c, c4_at(r, c), 28 + 4*c);
                end
            end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready4 = 1'b1;
        a4 = ident4();
        b4 = seq4();
        start4(1'b0);
        repeat (5) @(posedge clk);
        #1;
        total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b want=1", busy4); end
        #1;
        reset = 1'b1;
        #1;
        total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b want=1", in_ready4); end
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b want=0", out_valid4); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy4); end
        total++; if (c4 !== '0) begin bad++; $display("FAIL rmid_c got=%h want=0", c4); end
        a4 = '1;
        b4 = '1;
        @(negedge clk);
        reset = 1'b0;
        signed4 = 1'b0;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL rmid_first_edge_accept busy=%b want=1", busy4); end
        wait_out4(lat);
        total++; if (lat !== 10) begin bad++; $display("FAIL rmid_latency got=%0d want=10", lat); end
        total++; if (c4 !== {16{18'd260100}}) begin bad++; $display("FAIL rmid_c_after got=%h want all 260100", c4); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_param_n2();
        int lat;
        a2 = {4'd1, 4'd2, 4'd3, 4'd4};
        b2 = {4'd5, 4'd6, 4'd7, 4'd8};
        out_ready2 = 1'b1;
        @(negedge clk);
        signed2 = 1'b0;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++; if (lat !== 4) begin bad++; $display("FAIL n2_latency got=%0d want=4", lat); end
        total++; if (c2 !== {9'd19, 9'd22, 9'd43, 9'd50}) begin
            bad++; $display("FAIL n2_c got=%h want=%h", c2, {9'd19, 9'd22, 9'd43, 9'd50});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_param_n8();
        int lat;
        int s;
        byte ae [8][8];
        byte be [8][8];
        logic [18:0] got;
        logic [18:0] want;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                ae[r][c] = byte'($urandom);
                be[r][c] = byte'($urandom);
            end
        ae[0][0] = -128;
        be[0][0] = -128;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                a8[(63-(r*8+c))*8 +: 8] = ae[r][c];
                b8[(63-(r*8+c))*8 +: 8] = be[r][c];
            end
        out_ready8 = 1'b1;
        @(negedge clk);
        signed8 = 1'b1;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++; if (lat !== 22) begin bad++; $display("FAIL n8_latency got=%0d want=22", lat); end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                s = 0;
                for (int k = 0; k < 8; k++) s = s + ae[r][k] * be[k][c];
                want = 19'(s);
                got  = c8[(63-(r*8+c))*19 +: 19];
                total++;
                if (got !== want) begin
                    bad++; $display("FAIL n8_c[%0d][%0d] got=%h want=%h", r, c, got, want);
                end
            end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid4 = 1'b0; signed4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
        in_valid2 = 1'b0; signed2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
        in_valid8 = 1'b0; signed8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_identity();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_reset_mid();
        test_param_n2();
        test_param_n8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_mm_nxn.md
# systolic_mm_nxn

Parametrised output-stationary systolic matrix multiplier. It computes C = A × B for N×N matrices of DW-bit elements, in signed or unsigned mode. Whole operand matrices are accepted through a valid/ready handshake. The block skews them internally across an N×N PE grid and presents the full accumulated result through a second valid/ready handshake. It is the generalised replacement for the fixed 4×4 8-bit multiplier in the accelerator datapath.

## Interface
- N, 4, matrix dimension (N ≥ 2)
- DW, 8, operand element width in bits
- AW, 2*DW+$clog2(N), accumulator/result element width in bits
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operand matrices valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled on input handshake
- a_mat  in  N*N*DW  matrix A, row-major, element (0,0) in the MSBs
- b_mat  in  N*N*DW  matrix B, same packing as a_mat
- out_valid  out  1  c_mat holds a complete result
- out_ready  in  1  consumer accepts result
- c_mat  out  N*N*AW  result C, row-major, element (0,0) in the MSBs
- busy  out  1  high in COMPUTE and DONE

## Operation
- FSM has three states.
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - register a_mat, b_mat and signed_mode;
    - clear all N² accumulators;
    - clear step counter t to 0;
    - go to COMPUTE.
  - COMPUTE: each cycle, PE(i,j) receives a[i][k] and b[k][j], where k = t−i−j.
    - The product is accumulated only when 0 ≤ k < N; otherwise PE inputs are zero.
    - A values shift right one PE per cycle and B values shift down one PE per cycle. Skew is produced by per-row and per-column shift feeders.
    - t increments each cycle.
    - When t = 3N−3 the final products are accumulated and the FSM goes to DONE.
  - DONE: out_valid=1 and c_mat is stable.
    - On out_valid&&out_ready, go to IDLE.
    - Otherwise hold DONE indefinitely.
- Arithmetic:
  - Products are DW×DW→2DW, sign- or zero-extended to AW per the captured signed_mode.
  - Accumulation is modulo 2^AW (silent wrap if AW is overridden below its default).
- c_mat is driven directly from the accumulators, so it is only guaranteed meaningful while out_valid=1.
- in_valid outside IDLE is ignored. No operand buffering.
- Changing signed_mode, a_mat or b_mat after the input handshake has no effect on the current job.

## Timing
- Reset values:
  - state=IDLE, so in_ready=1;
  - out_valid=0 and busy=0;
  - c_mat=0, all accumulators=0, t=0, feeder and PE pipeline registers=0.
- Reset mid-operation (COMPUTE or DONE) aborts the job within the same cycle, asynchronously. No out_valid is produced. The next input handshake is possible on the first rising edge after reset deasserts.
- Latency: with the input handshake at edge E0, out_valid rises after edge E0+3N−2 (10 edges for N=4).
- in_ready falls after E0 and stays low through COMPUTE and DONE.
- Output handshake at edge E1 gives, after E1: out_valid=0, in_ready=1.
  - The next job's input handshake is at E1+1 at the earliest.
  - Throughput is therefore 1 job per 3N cycles with out_ready tied high.
- out_valid, once high, stays high with c_mat unchanged until accepted. Rule: no drop without a handshake.
- in_valid high together with out_valid&&out_ready: the input is not accepted that cycle (in_ready=0 in DONE).
- busy = (state≠IDLE), registered.

## Test plan
- Identity: A=I, B[r][c]=4r+c+1, unsigned, N=4, out_ready=1 → c_mat equals B, out_valid rises exactly 10 edges after input handshake, high for 1 cycle.
- Unsigned max: all elements 255 → every C element = 4·65025 = 260100 (fits AW=18), no wrap.
- Signed: A all −1 (8'hFF), B all 2, signed_mode=1 → every C element = −8 (18'h3FFF8). Same data with signed_mode=0 → 4·255·2 = 2040.
- Backpressure: out_ready=0 for 20 cycles after out_valid → c_mat and out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready → in_ready=1 next cycle. Back-to-back second job result is correct and independent of the first (accumulators cleared).
- Reset mid-COMPUTE at t=5 → all outputs at reset values immediately. New job after release completes correctly with normal latency.
- Parameter sweep: N=2, DW=4 (AW=9), A=[[1,2],[3,4]], B=[[5,6],[7,8]] unsigned → C=[[19,22],[43,50]], latency 4 edges. N=8 random signed vs. reference model, latency 22 edges.
